// File: rtl/data_mem_responder_if.sv
// Core-side data-memory bus plus the TX stream toward the external consumer.
// The master drives the core signals and out_ready; the slave is the responder.
interface data_mem_responder_if;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output MemWrite, ALUResult, WriteData, out_ready,
        input  ReadData, out_data, out_valid
    );

    modport slave (
        input  MemWrite, ALUResult, WriteData, out_ready,
        output ReadData, out_data, out_valid
    );
endinterface

// File: rtl/data_mem_responder.sv
// Data RAM plus an MMIO window at 0xF0000000: free-running cycle counter,
// TX FIFO push port and FIFO status. The FIFO drains over a valid/ready stream.
module data_mem_responder #(
    parameter int DEPTH      = 64,
    parameter int FIFO_DEPTH = 4
) (
    input logic               clk,
    input logic               reset,
    data_mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic [31:0]   ram  [DEPTH];
    logic [31:0]   fifo [FIFO_DEPTH];
    logic [31:0]   cycle;
    logic [FW-1:0] rptr, wptr;
    logic [CW-1:0] count;
    logic          ovf;

    logic          mmio;
    logic [1:0]    ridx;
    logic [AW-1:0] widx;
    logic          empty, full, pop, push, push_ok;
    logic          wr_cycle, wr_status, ovf_set, ovf_clr;
    logic [3:0]    cnt_disp;
    logic [31:0]   status;
    logic          unused_addr;

    assign mmio        = (bus.ALUResult[31:28] == 4'hF);
    assign ridx        = bus.ALUResult[3:2];
    assign widx        = bus.ALUResult[AW+1:2];
    assign unused_addr = ^bus.ALUResult;

    assign empty     = (count == '0);
    assign full      = (count == CW'(FIFO_DEPTH));
    assign pop       = !empty && bus.out_ready;
    assign push      = bus.MemWrite && mmio && (ridx == 2'd1);
    // A full FIFO still takes the push when the head leaves on the same edge.
    assign push_ok   = push && (!full || pop);
    assign wr_cycle  = bus.MemWrite && mmio && (ridx == 2'd0);
    assign wr_status = bus.MemWrite && mmio && (ridx == 2'd2);
    assign ovf_set   = push && full && !pop;
    assign ovf_clr   = wr_status && bus.WriteData[2];

    always_comb begin
        cnt_disp = 4'(count);
        if (32'(count) > 32'd15) cnt_disp = 4'hF;
    end

    assign status = {24'd0, cnt_disp, 1'b0, ovf, full, empty};

    always_comb begin
        bus.ReadData = ram[widx];
        if (mmio) begin
            case (ridx)
                2'd0:    bus.ReadData = cycle;
                2'd2:    bus.ReadData = status;
                default: bus.ReadData = 32'd0;
            endcase
        end
    end

    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? 32'd0 : fifo[rptr];

    // RAM and FIFO storage are not reset; FIFO contents are masked by count.
    always_ff @(posedge clk) begin
        if (bus.MemWrite && !mmio) ram[widx] <= bus.WriteData;
        if (push_ok)               fifo[wptr] <= bus.WriteData;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle <= '0;
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            cycle <= wr_cycle ? bus.WriteData : cycle + 32'd1;
            if (push_ok) wptr <= wptr + FW'(1);
            if (pop)     rptr <= rptr + FW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (ovf_set)      ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed MMIO/RAM checks plus a scoreboard
// of TX words compared against the stream as the consumer accepts them.
module tb_data_mem_responder;
    localparam int FD = 4;
    localparam logic [31:0] A_CYC = 32'hF000_0000;
    localparam logic [31:0] A_TX  = 32'hF000_0004;
    localparam logic [31:0] A_ST  = 32'hF000_0008;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] sb[$];

    data_mem_responder_if bus();

    data_mem_responder #(.DEPTH(64), .FIFO_DEPTH(FD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Stream monitor: sampled mid-cycle, a handshake here is a pop at the next edge.
    always @(negedge clk) begin
        chk("valid", {31'd0, bus.out_valid}, {31'd0, sb.size() != 0});
        if (!bus.out_valid) chk("data_idle", bus.out_data, 32'd0);
        else if (bus.out_ready) begin
            if (sb.size() == 0) chk("pop_unexpected", bus.out_data, 32'hxxxx_xxxx);
            else chk("pop_data", bus.out_data, sb.pop_front());
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic acc;
        bus.MemWrite  = 1'b1;
        bus.ALUResult = a;
        bus.WriteData = d;
        acc = (a[31:28] == 4'hF) && (a[3:2] == 2'd1) &&
              ((sb.size() < FD) || (bus.out_ready && sb.size() > 0));
        step();
        if (acc) sb.push_back(d);
        bus.MemWrite = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp);
        bus.MemWrite  = 1'b0;
        bus.ALUResult = a;
        #1;
        chk(tag, bus.ReadData, exp);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset         = 1'b0;
        bus.MemWrite  = 1'b0;
        bus.ALUResult = 32'd0;
        bus.WriteData = 32'd0;
        bus.out_ready = 1'b0;

        // Reset state, checked combinationally while held in reset.
        #2;
        bus.ALUResult = A_CYC; #1; chk("rst_cycle", bus.ReadData, 32'd0);
        bus.ALUResult = A_ST;  #1; chk("rst_status", bus.ReadData, 32'h1);
        chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_data", bus.out_data, 32'd0);

        // Release between edges; five edges later CYCLE reads 5.
        #8 reset = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        bus.ALUResult = A_CYC; #1; chk("cycle_5", bus.ReadData, 32'd5);
        step();

        wr(A_CYC, 32'hFFFF_FFFF);
        rd("cycle_load", A_CYC, 32'hFFFF_FFFF);
        rd("cycle_wrap", A_CYC, 32'h0000_0000);

        // RAM write/read and address aliasing modulo DEPTH words.
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_rd", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_alias", 32'h0000_0110, 32'hDEAD_BEEF);
        wr(32'h0000_00FC, 32'h1234_5678);
        rd("ram_top_alias", 32'h0ABC_01FC, 32'h1234_5678);
        rd("ram_keep", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("tx_rd_zero", A_TX, 32'd0);
        rd("rsvd_rd_zero", 32'hF000_000C, 32'd0);

        // FIFO ordering.
        wr(A_TX, 32'd1);
        wr(A_TX, 32'd2);
        wr(A_TX, 32'd3);
        rd("st_three", A_ST, 32'h30);
        bus.out_ready = 1'b1;
        repeat (3) step();
        rd("st_drained", A_ST, 32'h1);
        bus.out_ready = 1'b0;

        // Overflow: fifth word dropped, head unchanged, then clear overflow.
        wr(A_TX, 32'd11);
        wr(A_TX, 32'd12);
        wr(A_TX, 32'd13);
        wr(A_TX, 32'd14);
        wr(A_TX, 32'd15);
        rd("st_ovf", A_ST, 32'h46);
        chk("ovf_head", bus.out_data, 32'd11);
        wr(A_ST, 32'h4);
        rd("st_ovf_clr", A_ST, 32'h42);

        // Push while full and popping: accepted, no overflow, count stays 4.
        bus.out_ready = 1'b1;
        wr(A_TX, 32'hAA);
        bus.out_ready = 1'b0;
        rd("st_full_pp", A_ST, 32'h42);
        bus.out_ready = 1'b1;
        repeat (4) step();
        rd("st_drained2", A_ST, 32'h1);
        bus.out_ready = 1'b0;

        // Asynchronous reset mid-cycle with two words queued.
        wr(A_TX, 32'h21);
        wr(A_TX, 32'h22);
        #1 reset = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("arst_data", bus.out_data, 32'd0);
        sb.delete();
        #1 reset = 1'b1;
        step();
        rd("arst_status", A_ST, 32'h1);
        rd("arst_cycle", A_CYC, 32'd2);

        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder end of the processor's data-memory interface: accepts MemWrite/ALUResult/WriteData from the single-cycle core and returns ReadData in the same cycle. It contains a word-addressed data RAM plus a small memory-mapped I/O region. The region provides a cycle counter and a transmit FIFO, which drains to an external consumer over a valid/ready stream. It sits beside the core at top level, in place of a plain data memory.

## Interface
- DEPTH, 64: RAM size in 32-bit words; must be a power of two, at least 4.
- FIFO_DEPTH, 4: TX FIFO entries; must be a power of two, at least 2.

- clk  in  1  sole clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; asserting it clears all non-RAM state immediately.
- MemWrite  in  1  write strobe from the core, sampled at the rising edge.
- ALUResult  in  32  byte address from the core; bits [1:0] are ignored.
- WriteData  in  32  store data from the core.
- ReadData  out  32  load data, combinational from ALUResult.
- out_data  out  32  FIFO head word; 0 when out_valid=0.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts the head word this cycle.

## Operation
- Decode:
  - ALUResult[31:28]==4'hF selects MMIO, register index ALUResult[3:2].
  - Any other value selects RAM, word index ALUResult[log2(DEPTH)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH words.
- RAM:
  - Read is combinational.
  - Write occurs at the clock edge when MemWrite=1.
  - RAM contents are not affected by reset.
- MMIO index 0, CYCLE:
  - 32-bit counter, +1 every clock, wraps 0xFFFFFFFF -> 0.
  - A write loads WriteData; the increment is suppressed that cycle.
  - A read returns the current value.
- MMIO index 1, TXDATA:
  - A write pushes WriteData into the FIFO.
  - If the FIFO is full and no pop happens that cycle, the word is dropped and the sticky overflow bit is set.
  - A read returns 0.
- MMIO index 2, STATUS:
  - Read fields: [0] empty, [1] full, [2] overflow, [3] 0, [7:4] occupancy count (saturating display; FIFO_DEPTH ≤ 15), [31:8] 0.
  - A write with WriteData[2]=1 clears overflow. All other write bits are ignored.
- MMIO index 3: reserved. Reads return 0; writes are ignored.
- FIFO:
  - Circular buffer with read and write pointers plus a count.
  - A pop occurs when out_valid && out_ready at the edge.
  - Push and pop in the same cycle:
    - Both take effect and count is unchanged.
    - When full, the push is accepted and no overflow occurs.
    - When empty, only the push occurs (the pop is not valid).
  - No bypass: a word pushed into an empty FIFO appears on out_data the next cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- Overflow: set and clear in the same cycle resolves to set.

## Timing
- Reset values: CYCLE=0, FIFO empty (pointers 0, count 0), overflow=0, out_valid=0, out_data=0.
- ReadData reflects the state before the edge; a load following a store to the same address, one cycle later, returns the new value.
- CYCLE read in cycle N after reset release returns N. The first edge with reset high increments 0->1.
- out_valid rises one cycle after the first push. It falls one cycle after the pop that empties the FIFO.
- STATUS read in the same cycle as a TXDATA write shows pre-write state.
- Reset asserted mid-stream:
  - out_valid drops immediately (asynchronously), and queued words are lost.
  - The RAM write in progress at that edge is not guaranteed.
- MemWrite=0 never changes any state other than CYCLE increment and FIFO pop.

## Test plan
- RAM: store 0xDEADBEEF to 0x00000010, then load 0x00000010 -> 0xDEADBEEF. Load 0x00000110 with DEPTH=64 (alias) -> 0xDEADBEEF.
- CYCLE: release reset, read 0xF0000000 on the 5th cycle -> 5. Write 0xFFFFFFFF, then read for 2 cycles -> 0xFFFFFFFF, 0x00000000.
- FIFO order: with out_ready=0, push 1, 2, 3 -> STATUS count=3, empty=0. Raise out_ready -> out_data 1, 2, 3 on consecutive cycles, then out_valid=0 and STATUS.empty=1.
- Overflow: with out_ready=0, push 5 words (FIFO_DEPTH=4) -> full=1, overflow=1, head still word 1. Write STATUS 0x4 -> overflow=0, full=1.
- Full push+pop: FIFO full and out_ready=1, push 0xAA -> overflow stays 0, count stays 4, 0xAA is dequeued last.
- Async reset: with 2 words queued, pulse reset low mid-cycle -> out_valid=0 and out_data=0 immediately, STATUS=0x1 after release.
